// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_muldiv_unit_if : request/response bundle for the EX mul/div unit |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, op_a, op_b, flush, input busy, done, result);
  modport slave  (input start, op, op_a, op_b, flush, output busy, done, result);
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_muldiv_unit : iterative RV32M multiply/divide, one bit per cycle |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  ex_muldiv_unit_if.slave  bus
);

  localparam int              CW    = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, done_q, done_d;

  logic            accept, signed_a, signed_b, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum, div_sh;
  logic            div_ge;
  logic [XLEN-1:0] it_hi, it_lo, quo, rem, final_res;
  logic [2*XLEN-1:0] prod;

  // Operand decode for the request currently presented.
  always_comb begin
    accept   = (state_q == S_IDLE) && bus.start && !bus.flush;
    signed_a = bus.op[2] ? !bus.op[0] : (bus.op[1:0] != 2'b11);
    signed_b = bus.op[2] ? !bus.op[0] : !bus.op[1];
    sa       = signed_a & bus.op_a[XLEN-1];
    sb       = signed_b & bus.op_b[XLEN-1];
    abs_a    = sa ? -bus.op_a : bus.op_a;
    abs_b    = sb ? -bus.op_b : bus.op_b;
    div_zero = bus.op[2] && (bus.op_b == '0);
    div_ovf  = bus.op[2] && !bus.op[0] && (bus.op_a == C_MIN) && (bus.op_b == '1);
  end

  // One iteration: mul keeps partial product in hi and multiplier in lo;
  // div keeps partial remainder in hi and dividend/quotient bits in lo.
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    div_sh  = {hi_q, lo_q[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    if (op_q[2]) begin
      it_hi = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
      it_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      it_hi = mul_sum[XLEN:1];
      it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod      = neg_quo_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    quo       = neg_quo_q ? -it_lo : it_lo;
    rem       = neg_rem_q ? -it_hi : it_hi;
    final_res = '0;
    unique case (op_q)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = bus.op;
          neg_quo_d = sa ^ sb;
          neg_rem_d = sa;
          cnt_d     = CW'(XLEN);
          hi_d      = '0;
          lo_d      = bus.op[2] ? abs_a : abs_b;
          opnd_d    = bus.op[2] ? abs_b : abs_a;
          if (div_zero) begin
            result_d = bus.op[1] ? bus.op_a : {XLEN{1'b1}};
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = bus.op[1] ? {XLEN{1'b0}} : bus.op_a;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = it_hi;
          lo_d  = it_lo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = final_res;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC) || accept;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
`default_nettype wire
